sample_gate_detector: RTL

- Reads the signed 16-bit audio sample stream produced by a discrete sound circuit, such as the walk sound block, at the audio_clk_en rate.
- Recovers a clean digital "sound active" gate from that stream: full-wave rectifier, attack/release envelope follower, hysteresis comparator, and hold-count debounce state machine.
- Used for sound-presence status in the core and as a self-checking monitor that turns trigger-in/audio-out blocks back into trigger-out.

---
 rtl/sample_gate_detector_pkg.sv | 29 ++
 rtl/sample_gate_detector_envelope_follower.sv | 67 ++++++
 rtl/sample_gate_detector.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/sample_gate_detector_pkg.sv
// Shared definitions for the sound-gate detector: supply scale, sample type,
// the gate state encoding and the saturating rectifier.
package sample_gate_detector_pkg;

    localparam int VCC = 1 << 14;

    typedef logic signed [15:0] sample_t;

    localparam sample_t SAMPLE_MAX = sample_t'(2 * VCC - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARMING,
        ST_ACTIVE,
        ST_RELEASING
    } state_t;

    // The most negative sample has no positive twin, so it pins to full scale.
    function automatic sample_t sat_abs(input sample_t s);
        if (s == 16'sh8000) begin
            return SAMPLE_MAX;
        end else if (s < 0) begin
            return -s;
        end else begin
            return s;
        end
    endfunction

endpackage

// File: rtl/sample_gate_detector_envelope_follower.sv
// Envelope follower: full-wave rectifier, asymmetric attack/release step and
// clamp. env_next is exposed so the gate logic sees the value being loaded.
module sample_gate_detector_envelope_follower
    import sample_gate_detector_pkg::*;
#(
    parameter int ATTACK_SHIFT  = 2,
    parameter int RELEASE_SHIFT = 6
) (
    input  logic               clk,
    input  logic               I_RSTn,
    input  logic               audio_clk_en,
    input  logic signed [15:0] in,
    output logic signed [15:0] env_next,
    output logic signed [15:0] envelope
);

    sample_t            envelope_q;
    sample_t            envelope_d;
    logic signed [16:0] rect_w;
    logic signed [16:0] env_w;
    logic signed [16:0] diff;
    logic signed [16:0] mag;
    logic signed [16:0] step;
    logic signed [16:0] sum;

    // NOTE: every signal written here gets a value on every path first, so no latch is inferred.
    always_comb begin
        rect_w = {1'b0, sat_abs(in)};
        env_w  = {1'b0, envelope_q};
        diff   = rect_w - env_w;
        mag    = (diff < 0) ? -diff : diff;

        if (diff > 0) begin
            step = diff >>> ATTACK_SHIFT;
        end else begin
            step = mag >>> RELEASE_SHIFT;
        end
        // A minimum step of one guarantees exact convergence onto the input.
        if (diff != 0 && step == 0) begin
            step = 17'sd1;
        end

        sum = (diff < 0) ? env_w - step : env_w + step;

        if (sum > 17'sd32767) begin
            env_next = SAMPLE_MAX;
        end else if (sum < 0) begin
            env_next = '0;
        end else begin
            env_next = sum[15:0];
        end

        envelope_d = audio_clk_en ? env_next : envelope_q;
    end

    // NOTE: state uses non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge I_RSTn) begin
        if (!I_RSTn) begin
            envelope_q <= '0;
        end else begin
            envelope_q <= envelope_d;
        end
    end

    assign envelope = envelope_q;

endmodule

// File: rtl/sample_gate_detector.sv
// Sound-presence gate: envelope follower feeding a hysteresis comparator with
// hold-count debounce; produces a registered gate plus one-clk edge pulses.
module sample_gate_detector
    import sample_gate_detector_pkg::*;
#(
    parameter int ATTACK_SHIFT  = 2,
    parameter int RELEASE_SHIFT = 6,
    parameter int THRESH_ON     = 2048,
    parameter int THRESH_OFF    = 1024,
    parameter int HOLD_ON       = 8,
    parameter int HOLD_OFF      = 96
) (
    input  logic               clk,
    input  logic               I_RSTn,
    input  logic               audio_clk_en,
    input  logic signed [15:0] in,
    output logic signed [15:0] envelope,
    output logic               gate,
    output logic               gate_rise,
    output logic               gate_fall
);

    localparam int HOLD_MAX = (HOLD_ON > HOLD_OFF) ? HOLD_ON : HOLD_OFF;
    localparam int CW       = $clog2(HOLD_MAX + 1);

    localparam logic [CW-1:0] HOLD_ON_C  = CW'(HOLD_ON);
    localparam logic [CW-1:0] HOLD_OFF_C = CW'(HOLD_OFF);
    localparam sample_t       TH_ON      = sample_t'(THRESH_ON);
    localparam sample_t       TH_OFF     = sample_t'(THRESH_OFF);

    if (THRESH_OFF > THRESH_ON) begin : g_bad_thresh
        $error("sample_gate_detector: THRESH_OFF must not exceed THRESH_ON");
    end
    if (HOLD_ON < 1) begin : g_bad_hold_on
        $error("sample_gate_detector: HOLD_ON must be at least 1");
    end
    if (HOLD_OFF < 1) begin : g_bad_hold_off
        $error("sample_gate_detector: HOLD_OFF must be at least 1");
    end

    sample_t env_next;

    sample_gate_detector_envelope_follower #(
        .ATTACK_SHIFT (ATTACK_SHIFT),
        .RELEASE_SHIFT(RELEASE_SHIFT)
    ) u_envelope_follower (
        .clk         (clk),
        .I_RSTn      (I_RSTn),
        .audio_clk_en(audio_clk_en),
        .in          (in),
        .env_next    (env_next),
        .envelope    (envelope)
    );

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] cnt_inc;
    logic          gate_q, gate_d;
    logic          gate_rise_q, gate_rise_d;
    logic          gate_fall_q, gate_fall_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cnt_inc = cnt_q + CW'(1);

        if (audio_clk_en) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (env_next >= TH_ON) begin
                        if (HOLD_ON == 1) begin
                            state_d = ST_ACTIVE;
                            cnt_d   = '0;
                        end else begin
                            state_d = ST_ARMING;
                            cnt_d   = CW'(1);
                        end
                    end
                end
                ST_ARMING: begin
                    if (env_next < TH_ON) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end else if (cnt_inc == HOLD_ON_C) begin
                        state_d = ST_ACTIVE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                ST_ACTIVE: begin
                    if (env_next < TH_OFF) begin
                        if (HOLD_OFF == 1) begin
                            state_d = ST_IDLE;
                            cnt_d   = '0;
                        end else begin
                            state_d = ST_RELEASING;
                            cnt_d   = CW'(1);
                        end
                    end
                end
                ST_RELEASING: begin
                    if (env_next >= TH_OFF) begin
                        state_d = ST_ACTIVE;
                        cnt_d   = '0;
                    end else if (cnt_inc == HOLD_OFF_C) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end

        // Pulses follow gate edges; idle cycles leave gate unchanged, so they self-clear.
        gate_d      = (state_d == ST_ACTIVE) || (state_d == ST_RELEASING);
        gate_rise_d = gate_d & ~gate_q;
        gate_fall_d = ~gate_d & gate_q;
    end

    always_ff @(posedge clk or negedge I_RSTn) begin
        if (!I_RSTn) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            gate_q      <= 1'b0;
            gate_rise_q <= 1'b0;
            gate_fall_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            gate_q      <= gate_d;
            gate_rise_q <= gate_rise_d;
            gate_fall_q <= gate_fall_d;
        end
    end

    assign gate      = gate_q;
    assign gate_rise = gate_rise_q;
    assign gate_fall = gate_fall_q;

endmodule
